// File: rtl/pipe_ctrl_hazard.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl_hazard: D->E->M->W control registers and hazard/forward unit    |
// | Optional perf counters: HAZ_PERF_CNT_EN. Rev 1.0                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl_hazard #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic             ALUSrcD,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic [1:0]       ALUControlD,
    input  logic [1:0]       FlagWriteD,
    input  logic [3:0]       CondD,
    input  logic [RA_W-1:0]  RA1D,
    input  logic [RA_W-1:0]  RA2D,
    input  logic [RA_W-1:0]  WA3D,
    input  logic             PCSrcGE,
    input  logic             RegWriteGE,
    input  logic             MemWriteGE,
    input  logic             BranchTakenE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemtoRegE,
    output logic             ALUSrcE,
    output logic             BranchE,
    output logic             PCSrcE,
    output logic [1:0]       ALUControlE,
    output logic [1:0]       FlagWriteE,
    output logic [3:0]       CondE,
    output logic [RA_W-1:0]  WA3E,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic             PCSrcM,
    output logic [RA_W-1:0]  WA3M,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             PCSrcW,
    output logic [RA_W-1:0]  WA3W,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [RA_W-1:0]  c_PC_ADDR = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [RA_W-1:0] r_ra1e;
    logic [RA_W-1:0] r_ra2e;
    logic            w_ldr_stall;
    logic            w_pc_wr_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            BranchE     <= 1'b0;
            PCSrcE      <= 1'b0;
            ALUControlE <= 2'b00;
            FlagWriteE  <= 2'b00;
            CondE       <= 4'h0;
            WA3E        <= '0;
            r_ra1e      <= '0;
            r_ra2e      <= '0;
        end else begin
            RegWriteE   <= RegWriteD;
            MemWriteE   <= MemWriteD;
            MemtoRegE   <= MemtoRegD;
            ALUSrcE     <= ALUSrcD;
            BranchE     <= BranchD;
            PCSrcE      <= PCSrcD;
            ALUControlE <= ALUControlD;
            FlagWriteE  <= FlagWriteD;
            CondE       <= CondD;
            WA3E        <= WA3D;
            r_ra1e      <= RA1D;
            r_ra2e      <= RA2D;
        end
    end

    // M and W never stall or flush; condition gating is applied on entry to M.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcM    <= 1'b0;
            WA3M      <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            WA3W      <= '0;
        end else begin
            RegWriteM <= RegWriteGE;
            MemWriteM <= MemWriteGE;
            MemtoRegM <= MemtoRegE;
            PCSrcM    <= PCSrcGE;
            WA3M      <= WA3E;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            PCSrcW    <= PCSrcM;
            WA3W      <= WA3M;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic            rw_m,
        input logic [RA_W-1:0] wa_m,
        input logic            rw_w,
        input logic [RA_W-1:0] wa_w
    );
        if (ra == c_PC_ADDR)           return 2'b00;
        else if (rw_m && (ra == wa_m)) return 2'b10;
        else if (rw_w && (ra == wa_w)) return 2'b01;
        else                           return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(r_ra1e, RegWriteM, WA3M, RegWriteW, WA3W);
    assign ForwardBE = fwd_sel(r_ra2e, RegWriteM, WA3M, RegWriteW, WA3W);

    // Ungated RegWriteE: a load that later fails its condition still stalls.
    assign w_ldr_stall  = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign w_pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

    assign StallD = w_ldr_stall;
    assign StallF = w_ldr_stall | w_pc_wr_pend;
    assign FlushD = w_pc_wr_pend | PCSrcW | BranchTakenE;
    assign FlushE = w_ldr_stall | BranchTakenE;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (FlushE && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

`default_nettype wire
